// File: rtl/fetch_unit.sv
// fetch_unit -- single-outstanding instruction fetch with an instruction queue.
//
// Fetches one 32-bit instruction at a time from the icache. Each response is
// pushed into a small circular queue that feeds the decoder. The next PC is
// picked from a light predecode of the fetched word. A misprediction redirect
// (predict_fail) flushes the queue and reloads the PC. If a request is still
// in flight at that moment, its late response is discarded.
//
// Optional feature macro: FETCH_PREDICT_EN
//   defined   : B-type instructions are reported on pd_* and follow the
//               predictor (bp_need_branch / bp_branch_addr).
//   undefined : pd_branch is tied low and B-type always falls through to
//               pc+4. JAL still redirects. All ports stay present.

module fetch_unit #(
   parameter int          IQ_SIZE  = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   // icache request / response
   output logic        icache_req_valid,
   output logic [31:0] icache_req_addr,
   input  logic        icache_resp_valid,
   input  logic [31:0] icache_resp_inst,
   // predecode to / prediction from the branch predictor
   output logic        pd_branch,
   output logic [31:0] pd_imm,
   output logic [31:0] pd_pc,
   input  logic        bp_need_branch,
   input  logic [31:0] bp_branch_addr,
   // misprediction redirect
   input  logic        predict_fail,
   input  logic [31:0] fail_addr,
   // queue head to the decoder
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic        inst_pred,
   input  logic        dec_ready
);

   localparam int PTR_W = (IQ_SIZE > 1) ? $clog2(IQ_SIZE) : 1;
   localparam int CNT_W = $clog2(IQ_SIZE + 1);

   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(IQ_SIZE);
   localparam logic [6:0]       OP_BRANCH = 7'b1100011;
   localparam logic [6:0]       OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      ST_IDLE,     // free to issue a request
      ST_WAIT,     // one request in flight, its response will be used
      ST_DISCARD   // one request in flight, its response will be dropped
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [31:0]       r_pc;
   logic [31:0]       w_pc_nxt;

   // Instruction queue storage and pointers
   logic [31:0]       r_q_inst [IQ_SIZE];
   logic [31:0]       r_q_pc   [IQ_SIZE];
   logic [IQ_SIZE-1:0] r_q_pred;
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;

   // Qualifiers for this cycle
   logic              w_active;
   logic              w_queue_full;
   logic              w_req;
   logic              w_take_resp;
   logic              w_push;
   logic              w_pop;
   logic              w_flush;

   // Predecode of the incoming response word
   logic              w_is_jal;
   logic [31:0]       w_j_imm;
   logic [31:0]       w_seq_pc;
   logic [31:0]       w_resp_pc;
   logic              w_resp_pred;
   logic              w_pd_fire;

   // ---------------------------------------------------------------------
   // Cycle qualifiers
   // ---------------------------------------------------------------------
   // Nothing moves while the global ready is low or reset is held.
   assign w_active     = rdy_in & ~rst_in;
   assign w_queue_full = (r_count == FULL_CNT);

   // A request is issued only from IDLE with room left in the queue. The
   // queue cannot overflow because at most one response can be in flight.
   assign w_req        = w_active & (r_state == ST_IDLE) & ~w_queue_full & ~predict_fail;

   // A response is used only in WAIT. A same-cycle redirect voids it.
   assign w_take_resp  = w_active & (r_state == ST_WAIT) & icache_resp_valid & ~predict_fail;
   assign w_push       = w_take_resp;

   // A redirect voids any same-cycle pop as well.
   assign w_pop        = w_active & (r_count != '0) & dec_ready & ~predict_fail;
   assign w_flush      = w_active & predict_fail;

   // ---------------------------------------------------------------------
   // Predecode
   // ---------------------------------------------------------------------
   assign w_is_jal = (icache_resp_inst[6:0] == OP_JAL);
   assign w_j_imm  = {{12{icache_resp_inst[31]}}, icache_resp_inst[19:12],
                      icache_resp_inst[20], icache_resp_inst[30:21], 1'b0};
   assign w_seq_pc = r_pc + 32'd4;

`ifdef FETCH_PREDICT_EN
   logic              w_is_branch;
   logic [31:0]       w_b_imm;

   assign w_is_branch = (icache_resp_inst[6:0] == OP_BRANCH);
   assign w_b_imm     = {{20{icache_resp_inst[31]}}, icache_resp_inst[7],
                         icache_resp_inst[30:25], icache_resp_inst[11:8], 1'b0};
   assign w_pd_fire   = w_take_resp & w_is_branch;

   assign pd_branch   = w_pd_fire;
   assign pd_pc       = w_pd_fire ? r_pc    : '0;
   assign pd_imm      = w_pd_fire ? w_b_imm : '0;

   // Next-PC and taken flag for the fetched word, with branch prediction
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can
      // leave it unassigned and infer a latch.
      w_resp_pc   = w_seq_pc;
      w_resp_pred = 1'b0;
      if (w_is_jal) begin
         w_resp_pc   = r_pc + w_j_imm;
         w_resp_pred = 1'b1;
      end else if (w_is_branch && bp_need_branch) begin
         w_resp_pc   = bp_branch_addr;
         w_resp_pred = 1'b1;
      end
   end
`else
   // The predictor inputs are not used in this build.
   logic w_unused_bp;
   assign w_unused_bp = ^{bp_need_branch, bp_branch_addr, OP_BRANCH};

   assign w_pd_fire   = 1'b0;
   assign pd_branch   = 1'b0;
   assign pd_pc       = '0;
   assign pd_imm      = '0;

   // Next-PC and taken flag for the fetched word; only JAL redirects
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can
      // leave it unassigned and infer a latch.
      w_resp_pc   = w_seq_pc;
      w_resp_pred = 1'b0;
      if (w_is_jal) begin
         w_resp_pc   = r_pc + w_j_imm;
         w_resp_pred = 1'b1;
      end
   end
`endif

   // ---------------------------------------------------------------------
   // FSM and PC
   // ---------------------------------------------------------------------
   // Next-state and next-PC selection
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      if (w_active) begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  w_state_nxt = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (icache_resp_valid) begin
                  w_state_nxt = ST_IDLE;
               end else if (predict_fail) begin
                  w_state_nxt = ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (icache_resp_valid) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase

         if (predict_fail) begin
            w_pc_nxt = fail_addr;
         end else if (w_take_resp) begin
            w_pc_nxt = w_resp_pc;
         end
      end
   end

   // State and PC registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      // NOTE: registers are updated with non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      if (rst_in) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Instruction queue
   // ---------------------------------------------------------------------
   // Queue storage: write at the tail on push
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         // NOTE: the storage is cleared by reset so the head outputs are
         // defined from the first cycle, at the cost of resettable flops.
         for (int i = 0; i < IQ_SIZE; i++) begin
            r_q_inst[i] <= '0;
            r_q_pc[i]   <= '0;
         end
         r_q_pred <= '0;
      end else if (w_push) begin
         r_q_inst[r_tail] <= icache_resp_inst;
         r_q_pc[r_tail]   <= r_pc;
         r_q_pred[r_tail] <= w_resp_pred;
      end
   end

   // Queue pointers and occupancy; a redirect empties the queue
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (w_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign icache_req_valid = w_req;
   assign icache_req_addr  = w_req ? r_pc : '0;

   assign inst_valid = ~rst_in & (r_count != '0);
   assign inst_out   = inst_valid ? r_q_inst[r_head] : '0;
   assign inst_pc    = inst_valid ? r_q_pc[r_head]   : '0;
   assign inst_pred  = inst_valid & r_q_pred[r_head];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
// Directed scenarios with literal expectations come first. A long randomized
// run follows, with an icache responder driven by $urandom. Every cycle the
// DUT outputs are compared against a queue-based reference model of the
// fetch behaviour.

module tb_fetch_unit;

   localparam int          IQ_SIZE  = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_PREDICT_EN
   localparam bit PRED_EN = 1'b1;
`else
   localparam bit PRED_EN = 1'b0;
`endif

   typedef enum int {K_OTHER, K_BR, K_JAL, K_JALR} kind_e;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pred;
   } entry_t;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        req_v;
   logic [31:0] req_addr;
   logic        resp_v;
   logic [31:0] resp_inst;
   logic        pd_br;
   logic [31:0] pd_imm;
   logic [31:0] pd_pc;
   logic        bp_nb;
   logic [31:0] bp_addr;
   logic        pf;
   logic [31:0] faddr;
   logic        i_valid;
   logic [31:0] i_out;
   logic [31:0] i_pc;
   logic        i_pred;
   logic        dready;

   // What the bench knows about the word currently on icache_resp_inst
   kind_e       resp_kind;
   int          resp_imm;

   // Reference model
   entry_t      m_q[$];
   logic [31:0] m_pc;
   bit          m_busy;   // request in flight, response will be used
   bit          m_drop;   // request in flight, response will be discarded

   // Auto icache responder
   bit          auto_ic;
   bit          ic_pending;
   int unsigned ic_delay;

   int          n_checks;
   int          n_err;

   fetch_unit #(.IQ_SIZE(IQ_SIZE), .RESET_PC(RESET_PC)) dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .rdy_in            (rdy),
      .icache_req_valid  (req_v),
      .icache_req_addr   (req_addr),
      .icache_resp_valid (resp_v),
      .icache_resp_inst  (resp_inst),
      .pd_branch         (pd_br),
      .pd_imm            (pd_imm),
      .pd_pc             (pd_pc),
      .bp_need_branch    (bp_nb),
      .bp_branch_addr    (bp_addr),
      .predict_fail      (pf),
      .fail_addr         (faddr),
      .inst_valid        (i_valid),
      .inst_out          (i_out),
      .inst_pc           (i_pc),
      .inst_pred         (i_pred),
      .dec_ready         (dready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Instruction builders: the immediate is placed into the encoding, so the
   // model knows the value directly without decoding the word.
   function automatic logic [31:0] enc_b(input int imm);
      logic [12:0] v;
      logic [31:0] r;
      v = imm[12:0];
      r = $urandom();
      return {v[12], v[10:5], r[24:20], r[19:15], r[14:12], v[4:1], v[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input int imm);
      logic [20:0] v;
      logic [31:0] r;
      v = imm[20:0];
      r = $urandom();
      return {v[20], v[10:1], v[11], v[19:12], r[11:7], 7'b1101111};
   endfunction

   task automatic set_resp(input logic [31:0] inst, input kind_e k, input int imm);
      resp_inst = inst;
      resp_kind = k;
      resp_imm  = imm;
   endtask

   task automatic random_resp();
      int unsigned sel;
      logic [31:0] r;
      int          imm;
      sel = $urandom_range(0, 9);
      r   = $urandom();
      if (sel <= 3) begin
         case (sel)
            0:       set_resp({r[31:7], 7'b0010011}, K_OTHER, 0);
            1:       set_resp({r[31:7], 7'b0110011}, K_OTHER, 0);
            2:       set_resp({r[31:7], 7'b0000011}, K_OTHER, 0);
            default: set_resp({r[31:7], 7'b0110111}, K_OTHER, 0);
         endcase
      end else if (sel <= 6) begin
         imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
         set_resp(enc_b(imm), K_BR, imm);
      end else if (sel <= 8) begin
         imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
         set_resp(enc_j(imm), K_JAL, imm);
      end else begin
         set_resp({r[31:7], 7'b1100111}, K_JALR, 0);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc       = RESET_PC;
      m_busy     = 1'b0;
      m_drop     = 1'b0;
      ic_pending = 1'b0;
   endtask

   // Reset: held for two cycles; all outputs must read zero while it is high
   task automatic do_reset();
      rst    = 1'b1;
      rdy    = 1'b1;
      resp_v = 1'b0;
      pf     = 1'b0;
      dready = 1'b1;
      bp_nb  = 1'b1;
      #1;
      check("rst_req_valid", req_v, 1'b0);
      check("rst_req_addr", req_addr, 32'h0);
      check("rst_pd_branch", pd_br, 1'b0);
      check("rst_pd_imm", pd_imm, 32'h0);
      check("rst_pd_pc", pd_pc, 32'h0);
      check("rst_inst_valid", i_valid, 1'b0);
      check("rst_inst_out", i_out, 32'h0);
      check("rst_inst_pc", i_pc, 32'h0);
      check("rst_inst_pred", i_pred, 1'b0);
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      bp_nb  = 1'b0;
      model_reset();
   endtask

   // One clock cycle: compare the DUT outputs against the model, advance the
   // model, then wait until the next falling edge for fresh stimulus.
   task automatic step();
      bit     exp_req;
      bit     exp_pd;
      bit     exp_valid;
      entry_t e;
      if (auto_ic) begin
         resp_v = 1'b0;
         if (ic_pending && rdy) begin
            if (ic_delay == 0) begin
               random_resp();
               resp_v     = 1'b1;
               ic_pending = 1'b0;
            end else begin
               ic_delay--;
            end
         end
      end
      #1;
      exp_req   = rdy && !m_busy && !m_drop && (m_q.size() < IQ_SIZE) && !pf;
      exp_pd    = PRED_EN && rdy && m_busy && resp_v && !pf && (resp_kind == K_BR);
      exp_valid = (m_q.size() != 0);

      check("req_valid", req_v, exp_req);
      if (exp_req) check("req_addr", req_addr, m_pc);
      check("pd_branch", pd_br, exp_pd);
      check("pd_pc", pd_pc, exp_pd ? m_pc : 32'h0);
      check("pd_imm", pd_imm, exp_pd ? 32'(resp_imm) : 32'h0);
      check("inst_valid", i_valid, exp_valid);
      if (exp_valid) begin
         check("inst_out", i_out, m_q[0].inst);
         check("inst_pc", i_pc, m_q[0].pc);
         check("inst_pred", i_pred, m_q[0].pred);
      end

      if (rdy) begin
         if (pf) begin
            m_q.delete();
            m_pc = faddr;
            if (m_busy || m_drop) begin
               m_busy = 1'b0;
               m_drop = !resp_v;
            end
         end else begin
            if (exp_valid && dready) void'(m_q.pop_front());
            if (exp_req) begin
               m_busy = 1'b1;
            end else if (m_busy && resp_v) begin
               e.inst = resp_inst;
               e.pc   = m_pc;
               case (resp_kind)
                  K_BR: begin
                     e.pred = PRED_EN && bp_nb;
                     m_pc   = e.pred ? bp_addr : m_pc + 32'd4;
                  end
                  K_JAL: begin
                     e.pred = 1'b1;
                     m_pc   = m_pc + 32'(resp_imm);
                  end
                  default: begin
                     e.pred = 1'b0;
                     m_pc   = m_pc + 32'd4;
                  end
               endcase
               m_q.push_back(e);
               m_busy = 1'b0;
            end else if (m_drop && resp_v) begin
               m_drop = 1'b0;
            end
         end
      end

      if (auto_ic && req_v) begin
         ic_pending = 1'b1;
         ic_delay   = $urandom_range(0, 2);
      end
      @(negedge clk);
   endtask

   initial begin
      int slow_phase;
      n_checks  = 0;
      n_err     = 0;
      auto_ic   = 1'b0;
      resp_inst = 32'h0;
      resp_kind = K_OTHER;
      resp_imm  = 0;
      bp_addr   = 32'h0;
      faddr     = 32'h0;
      model_reset();
      do_reset();

      // ---- ADDI at reset PC: request at 0x0, then at 0x4 ----
      rdy = 1'b1; dready = 1'b0; pf = 1'b0; resp_v = 1'b0; bp_nb = 1'b0;
      #1;
      check("addi_req_valid", req_v, 1'b1);
      check("addi_req_addr", req_addr, 32'h0);
      step();
      resp_v = 1'b1; set_resp(32'h00100093, K_OTHER, 0);
      step();
      resp_v = 1'b0;
      #1;
      check("addi_next_req", req_addr, 32'h4);
      check("addi_inst_valid", i_valid, 1'b1);
      check("addi_inst_pc", i_pc, 32'h0);
      check("addi_inst_pred", i_pred, 1'b0);
      step();

      // ---- redirect to 0x100 while waiting, then drop the late response ----
      pf = 1'b1; faddr = 32'h100;
      #1;
      check("pf_wait_no_req", req_v, 1'b0);
      step();
      pf = 1'b0; resp_v = 1'b1; set_resp(32'h00200113, K_OTHER, 0);
      #1;
      check("discard_no_req", req_v, 1'b0);
      check("discard_q_empty", i_valid, 1'b0);
      step();
      resp_v = 1'b0;
      #1;
      check("redir_req_addr", req_addr, 32'h100);
      step();

      // ---- BEQ +16 at 0x100 with a taken prediction to 0x110 ----
      resp_v = 1'b1; set_resp(32'h00000863, K_BR, 16);
      bp_nb = 1'b1; bp_addr = 32'h110;
      #1;
      check("beq_pd_branch", pd_br, PRED_EN);
      if (PRED_EN) begin
         check("beq_pd_pc", pd_pc, 32'h100);
         check("beq_pd_imm", pd_imm, 32'h10);
      end
      step();
      resp_v = 1'b0; bp_nb = 1'b0;
      #1;
      check("beq_next_req", req_addr, PRED_EN ? 32'h110 : 32'h104);
      check("beq_inst_pc", i_pc, 32'h100);
      check("beq_inst_pred", i_pred, PRED_EN);
      step();

      // ---- redirect to 0x200 in WAIT: queue empties, late response dropped ----
      pf = 1'b1; faddr = 32'h200;
      step();
      pf = 1'b0; resp_v = 1'b1; set_resp(32'h00300193, K_OTHER, 0);
      #1;
      check("pf200_q_empty", i_valid, 1'b0);
      step();
      resp_v = 1'b0;
      #1;
      check("pf200_req_valid", req_v, 1'b1);
      check("pf200_req_addr", req_addr, 32'h200);
      check("pf200_dropped", i_valid, 1'b0);
      step();

      // ---- redirect in the same cycle as a response: response dropped ----
      resp_v = 1'b1; set_resp(32'h00400213, K_OTHER, 0);
      pf = 1'b1; faddr = 32'h40;
      #1;
      check("pfresp_pd_branch", pd_br, 1'b0);
      step();
      resp_v = 1'b0; pf = 1'b0;
      #1;
      check("pfresp_req_valid", req_v, 1'b1);
      check("pfresp_req_addr", req_addr, 32'h40);
      check("pfresp_dropped", i_valid, 1'b0);
      step();

      // ---- JAL -8 at 0x40 ----
      resp_v = 1'b1; set_resp(32'hFF9FF06F, K_JAL, -8);
      #1;
      check("jal_pd_branch", pd_br, 1'b0);
      step();
      resp_v = 1'b0;
      #1;
      check("jal_next_req", req_addr, 32'h38);
      check("jal_inst_out", i_out, 32'hFF9FF06F);
      check("jal_inst_pc", i_pc, 32'h40);
      check("jal_inst_pred", i_pred, 1'b1);
      step();

      // ---- fill the queue with the decoder stalled ----
      for (int k = 0; k < 3; k++) begin
         resp_v = 1'b1; set_resp(32'h00000013, K_OTHER, 0);
         step();
         resp_v = 1'b0;
         if (k < 2) step();
      end
      for (int k = 0; k < 3; k++) begin
         #1;
         check("full_no_req", req_v, 1'b0);
         check("full_valid", i_valid, 1'b1);
         step();
      end
      dready = 1'b1;
      step();
      dready = 1'b0;
      #1;
      check("pop_one_req", req_v, 1'b1);
      check("pop_one_addr", req_addr, 32'h44);
      step();
      #1;
      check("pop_only_one", req_v, 1'b0);
      step();

      // ---- randomized run with the auto icache ----
      do_reset();
      auto_ic    = 1'b1;
      slow_phase = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) begin
            do_reset();
         end
         if ((i % 150) == 0) slow_phase = $urandom_range(0, 1);
         rdy     = ($urandom_range(0, 7) != 0);
         dready  = slow_phase ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
         pf      = ($urandom_range(0, 24) == 0);
         faddr   = $urandom() & 32'hFFFF_FFFC;
         bp_nb   = $urandom_range(0, 1);
         bp_addr = $urandom() & 32'hFFFF_FFFC;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
